// File: rtl/control_vga_pkg.sv
// Shared timing, layout and colour constants for the VGA clock/date/timer renderer.
package control_vga_pkg;

  typedef logic [10:0] coord_t;
  typedef logic [11:0] rgb_t;

  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_V_VIS   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;
  localparam int VGA_PIX_DIV = 4;
  localparam int VGA_BLINK   = 5;

  // Bands stack vertically on a 140-line pitch; fields sit 20 lines below the band top.
  localparam int BAND_X0     = 60;
  localparam int BAND_X1     = 579;
  localparam int BAND_Y0     = 30;
  localparam int BAND_PITCH  = 140;
  localparam int BAND_H      = 140;
  localparam int FRAME_W     = 4;
  localparam int FIELD_X0    = 80;
  localparam int FIELD_PITCH = 180;
  localparam int FIELD_W     = 120;
  localparam int FIELD_DY    = 20;
  localparam int FIELD_H     = 100;
  localparam int IND_X0      = 600;
  localparam int IND_X1      = 629;
  localparam int FMT_Y0      = 40;
  localparam int FMT_Y1      = 69;
  localparam int PM_Y0       = 80;
  localparam int PM_Y1       = 109;

  localparam rgb_t C_BLACK   = 12'h000;
  localparam rgb_t C_BG      = 12'h008;
  localparam rgb_t C_FIELD   = 12'h0F0;
  localparam rgb_t C_HILITE  = 12'hFF0;
  localparam rgb_t C_FRAME   = 12'hFFF;
  localparam rgb_t C_ALARM   = 12'hF00;
  localparam rgb_t C_IND_ON  = 12'hF00;
  localparam rgb_t C_PM      = 12'h0FF;
  localparam rgb_t C_IND_OFF = 12'h444;

  function automatic logic in_rect(input coord_t x, input coord_t y,
                                   input int x0, input int x1, input int y0, input int y1);
    return (int'(x) >= x0) && (int'(x) <= x1) && (int'(y) >= y0) && (int'(y) <= y1);
  endfunction

endpackage

// File: rtl/control_vga_sync.sv
// Pixel-rate divider, raster counters, sync/visible decode and frame counter (unregistered outputs).
module vga_sync
  import control_vga_pkg::*;
#(
  parameter int H_VIS     = VGA_H_VIS,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VIS     = VGA_V_VIS,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int PIX_DIV   = VGA_PIX_DIV,
  parameter int BLINK_BIT = VGA_BLINK
) (
  input  logic   reloj_nexys,
  input  logic   reset_total,
  output coord_t h_cnt,
  output coord_t v_cnt,
  output logic   hsync_n,
  output logic   vsync_n,
  output logic   visible,
  output logic   blink_off
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0]   div_cnt;
  logic [BLINK_BIT:0] frame_cnt;
  logic               pix_en;
  logic               h_last;

  assign pix_en = (div_cnt == DIV_W'(PIX_DIV - 1));
  assign h_last = (h_cnt == coord_t'(H_TOTAL - 1));

  always_ff @(posedge reloj_nexys or negedge reset_total) begin
    if (!reset_total) begin
      div_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
      if (pix_en) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == coord_t'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
          // Frame count steps as the raster enters vertical sync.
          if (v_cnt == coord_t'(V_VIS + V_FP - 1))
            frame_cnt <= frame_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign hsync_n   = !((int'(h_cnt) >= H_VIS + H_FP) && (int'(h_cnt) < H_VIS + H_FP + H_SYNC));
  assign vsync_n   = !((int'(v_cnt) >= V_VIS + V_FP) && (int'(v_cnt) < V_VIS + V_FP + V_SYNC));
  assign visible   = (int'(h_cnt) < H_VIS) && (int'(v_cnt) < V_VIS);
  assign blink_off = frame_cnt[BLINK_BIT];

endmodule

// File: rtl/control_vga.sv
// VGA renderer: region decode of the raster position, colour priority mux and output registers.
module control_vga
  import control_vga_pkg::*;
#(
  parameter int H_VIS     = VGA_H_VIS,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VIS     = VGA_V_VIS,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int PIX_DIV   = VGA_PIX_DIV,
  parameter int BLINK_BIT = VGA_BLINK
) (
  input  logic        reloj_nexys,
  input  logic        reset_total,
  input  logic [1:0]  direc_prog,
  input  logic [2:0]  prog_hora,
  input  logic [2:0]  prog_fecha,
  input  logic [2:0]  prog_crono,
  input  logic        crono_final,
  input  logic        tiempo,
  input  logic        formato,
  output logic [11:0] color_salida,
  output logic        hsync,
  output logic        vsync
);

  coord_t     h_cnt, v_cnt;
  logic       hsync_n, vsync_n, visible, blink_off;
  logic [8:0] field_hit, prog_all;
  logic [2:0] frame_hit;
  logic       fmt_hit, pm_hit;
  rgb_t       color_next;

  vga_sync #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV), .BLINK_BIT(BLINK_BIT)
  ) u_sync (
    .reloj_nexys(reloj_nexys),
    .reset_total(reset_total),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .visible    (visible),
    .blink_off  (blink_off)
  );

  assign prog_all = {prog_crono, prog_fecha, prog_hora};
  assign fmt_hit  = in_rect(h_cnt, v_cnt, IND_X0, IND_X1, FMT_Y0, FMT_Y1);
  assign pm_hit   = in_rect(h_cnt, v_cnt, IND_X0, IND_X1, PM_Y0, PM_Y1);

  generate
    for (genvar k = 0; k < 3; k++) begin : g_band
      localparam int Y0 = BAND_Y0 + k * BAND_PITCH;
      localparam int Y1 = Y0 + BAND_H - 1;
      // Frame ring: inside the band rectangle but outside its 4-pixel inset.
      assign frame_hit[k] = (direc_prog == 2'(k + 1))
                         && in_rect(h_cnt, v_cnt, BAND_X0, BAND_X1, Y0, Y1)
                         && !in_rect(h_cnt, v_cnt, BAND_X0 + FRAME_W, BAND_X1 - FRAME_W,
                                     Y0 + FRAME_W, Y1 - FRAME_W);
      for (genvar j = 0; j < 3; j++) begin : g_field
        assign field_hit[3*k+j] = in_rect(h_cnt, v_cnt,
                                          FIELD_X0 + j * FIELD_PITCH,
                                          FIELD_X0 + j * FIELD_PITCH + FIELD_W - 1,
                                          Y0 + FIELD_DY, Y0 + FIELD_DY + FIELD_H - 1);
      end
    end
  endgenerate

  always_comb begin
    color_next = C_BLACK;
    if (visible) begin
      if (fmt_hit)
        color_next = formato ? C_IND_ON : C_IND_OFF;
      else if (pm_hit)
        color_next = (formato && tiempo) ? C_PM : C_IND_OFF;
      else if (|frame_hit)
        color_next = C_FRAME;
      else if (crono_final && !blink_off && |field_hit[8:6])
        color_next = C_ALARM;
      else if (|(field_hit & prog_all))
        color_next = C_HILITE;
      else if (|field_hit)
        color_next = C_FIELD;
      else
        color_next = C_BG;
    end
  end

  always_ff @(posedge reloj_nexys or negedge reset_total) begin
    if (!reset_total) begin
      color_salida <= C_BLACK;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
    end else begin
      color_salida <= color_next;
      hsync        <= hsync_n;
      vsync        <= vsync_n;
    end
  end

endmodule

// File: tb/tb_control_vga.sv
// Self-checking bench: free-run sync timing, plus pinned raster positions checked against a vector table.
module tb_control_vga;
  import control_vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset_total;
  logic [1:0]  direc_prog;
  logic [2:0]  prog_hora, prog_fecha, prog_crono;
  logic        crono_final, tiempo, formato;
  logic [11:0] color_salida;
  logic        hsync, vsync;

  int n_tests = 0;
  int n_fail  = 0;

  coord_t     f_h, f_v;
  logic [5:0] f_frame;

  typedef struct {
    int          h, v;
    logic [1:0]  dp;
    logic [2:0]  ph, pf, pc;
    logic        fin, tie, fmt;
    logic [5:0]  frame;
    logic [11:0] col;
    logic        hs, vs;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  control_vga dut (
    .reloj_nexys (clk),
    .reset_total (reset_total),
    .direc_prog  (direc_prog),
    .prog_hora   (prog_hora),
    .prog_fecha  (prog_fecha),
    .prog_crono  (prog_crono),
    .crono_final (crono_final),
    .tiempo      (tiempo),
    .formato     (formato),
    .color_salida(color_salida),
    .hsync       (hsync),
    .vsync       (vsync)
  );

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
    end
  endtask

  // Expected syncs come from the standard 640x480 timing windows.
  task automatic add(input int h, input int v, input logic [11:0] col, input logic [1:0] dp,
                     input logic [2:0] ph, input logic [2:0] pf, input logic [2:0] pc,
                     input logic fin, input logic tie, input logic fmt, input int frame);
    vec_t e;
    e.h = h; e.v = v; e.col = col; e.dp = dp;
    e.ph = ph; e.pf = pf; e.pc = pc;
    e.fin = fin; e.tie = tie; e.fmt = fmt; e.frame = 6'(frame);
    e.hs = !(h >= 656 && h <= 751);
    e.vs = !(v >= 490 && v <= 491);
    vecs.push_back(e);
  endtask

  // Counts rising edges until hsync reaches the given level; -1 on timeout.
  task automatic wait_hsync(input logic level, input int max_clk, output int n);
    n = -1;
    for (int i = 1; i <= max_clk; i++) begin
      @(posedge clk); #1;
      if (hsync == level) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_first_fall(input string name);
    int n;
    wait_hsync(1'b0, 4000, n);
    n_tests++;
    if (n < 2623 || n > 2626) begin
      n_fail++;
      $display("FAIL %s: got %0d clocks, want 2624 (+/-1 plus output register)", name, n);
    end
  endtask

  initial begin
    int n;
    vec_t e;
    reset_total = 1'b0;
    direc_prog = 2'd0; prog_hora = 3'd0; prog_fecha = 3'd0; prog_crono = 3'd0;
    crono_final = 1'b0; tiempo = 1'b0; formato = 1'b0;
    f_h = '0; f_v = '0; f_frame = '0;

    //   h    v    colour    dp    hora    fecha   crono   fin   tie   fmt  frame
    add(100, 200, 12'hFF0, 2'd0, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(300, 200, 12'h0F0, 2'd0, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(100,  60, 12'h0F0, 2'd0, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add( 30,  10, 12'h008, 2'd0, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add( 61,  35, 12'hFFF, 2'd1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add( 61,  35, 12'h008, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add( 61, 315, 12'hFFF, 2'd3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add( 61, 315, 12'h008, 2'd1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add( 61, 175, 12'hFFF, 2'd2, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(300, 169, 12'hFFF, 2'd1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(300, 166, 12'hFFF, 2'd1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(300, 165, 12'h008, 2'd1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(576, 100, 12'hFFF, 2'd1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(575, 100, 12'h008, 2'd1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(100, 400, 12'hF00, 2'd0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 0);
    add(100, 400, 12'hF00, 2'd0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 31);
    add(100, 400, 12'h0F0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 32);
    add(500, 400, 12'h0F0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 63);
    add(100, 400, 12'hF00, 2'd0, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 0);
    add(100, 400, 12'hFF0, 2'd0, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 32);
    add(100, 200, 12'h0F0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 0);
    add(100,  60, 12'hFF0, 2'd0, 3'b101, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(500,  60, 12'hFF0, 2'd0, 3'b101, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(300,  60, 12'h0F0, 2'd0, 3'b101, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add( 80,  50, 12'h0F0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add( 79,  50, 12'h008, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(199, 149, 12'h0F0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(200, 149, 12'h008, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(610,  50, 12'hF00, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 0);
    add(610,  90, 12'h0FF, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 0);
    add(610,  50, 12'h444, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 0);
    add(610,  90, 12'h444, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 0);
    add(610,  90, 12'h444, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 0);
    add(639, 479, 12'h008, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(640, 100, 12'h000, 2'd1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 0);
    add(100, 480, 12'h000, 2'd0, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 0);
    add(655,   0, 12'h000, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(656,   0, 12'h000, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(751,   0, 12'h000, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(752,   0, 12'h000, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(  0, 489, 12'h000, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(  0, 490, 12'h000, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(700, 491, 12'h000, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    add(  0, 492, 12'h000, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0);

    // Reset state and release timing.
    repeat (5) @(negedge clk);
    check("reset_color", int'(color_salida), 0);
    check("reset_hsync", int'(hsync), 1);
    check("reset_vsync", int'(vsync), 1);
    reset_total = 1'b1;
    check_first_fall("first_hsync_fall");
    check("blank_color_in_hsync", int'(color_salida), 0);
    wait_hsync(1'b1, 1000, n);
    check("hsync_low_clocks", n, 384);
    wait_hsync(1'b0, 4000, n);
    check("hsync_high_clocks", n, 3200 - 384);

    // Pin the raster position and step through the vector table.
    force dut.u_sync.h_cnt     = f_h;
    force dut.u_sync.v_cnt     = f_v;
    force dut.u_sync.frame_cnt = f_frame;
    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("color(%0d,%0d)", e.h, e.v), int'(color_salida), int'(e.col));
        check($sformatf("hsync(%0d,%0d)", e.h, e.v), int'(hsync), int'(e.hs));
        check($sformatf("vsync(%0d,%0d)", e.h, e.v), int'(vsync), int'(e.vs));
      end
      if (i < vecs.size()) begin
        e = vecs[i];
        f_h = coord_t'(e.h); f_v = coord_t'(e.v); f_frame = e.frame;
        direc_prog = e.dp; prog_hora = e.ph; prog_fecha = e.pf; prog_crono = e.pc;
        crono_final = e.fin; tiempo = e.tie; formato = e.fmt;
        exp_q.push_back(e);
      end
    end

    // Mid-frame reset with a visible, lit pixel pinned.
    f_h = coord_t'(610); f_v = coord_t'(50); formato = 1'b1;
    @(negedge clk);
    check("pre_reset_color", int'(color_salida), 12'hF00);
    reset_total = 1'b0;
    #1;
    check("async_reset_color", int'(color_salida), 0);
    release dut.u_sync.h_cnt;
    release dut.u_sync.v_cnt;
    release dut.u_sync.frame_cnt;
    repeat (3) @(negedge clk);
    check("midreset_hsync", int'(hsync), 1);
    check("midreset_vsync", int'(vsync), 1);
    reset_total = 1'b1;
    check_first_fall("restart_hsync_fall");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
